gate_test: RTL and testbench

GATE_TEST -- requirements
Module: gate_test

---
 rtl/gate_test_pkg.sv | 11 +
 rtl/gate_test_core.sv | 26 ++
 rtl/gate_test.sv | 60 ++++++
 tb/tb_gate_test.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared constants for the gate_test block: gate function encodings and counter width.
package gate_test_pkg;

    localparam logic [1:0] MODE_AOI = 2'd0;
    localparam logic [1:0] MODE_AO  = 2'd1;
    localparam logic [1:0] MODE_OAI = 2'd2;
    localparam logic [1:0] MODE_XOR = 2'd3;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/gate_test_core.sv
// Combinational gate evaluator: selects one of four 6-input gate functions by mode.
module gate_test_core
    import gate_test_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic [1:0] mode,
    output logic       f
);

    always_comb begin
        f = 1'b0;
        unique case (mode)
            MODE_AOI: f = ~((A & B) | (C & D) | (E & F));
            MODE_AO:  f =   (A & B) | (C & D) | (E & F);
            MODE_OAI: f = ~((A | B) & (C | D) & (E | F));
            MODE_XOR: f = A ^ B ^ C ^ D ^ E ^ F;
            default:  f = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_test.sv
// Registered selectable gate with sample enable and async reset.
// Optional saturating Y-transition counter enabled by GATE_TEST_TOGGLE_CNT_EN.
module gate_test
    import gate_test_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    input  logic             F,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             Y
`ifdef GATE_TEST_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    logic f;

    gate_test_core u_core (
        .A    (A),
        .B    (B),
        .C    (C),
        .D    (D),
        .E    (E),
        .F    (F),
        .mode (mode),
        .f    (f)
    );

    // Y comes straight from this flop so it cannot glitch between edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y <= 1'b0;
        end else if (en) begin
            Y <= f;
        end
    end

`ifdef GATE_TEST_TOGGLE_CNT_EN
    logic toggle_c;

    assign toggle_c = en & (f != Y);

    // Counts edges where Y will change value; sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (toggle_c && (toggle_cnt != {CNT_W{1'b1}})) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gate_test.sv
// Scoreboard bench for gate_test: stimulus queues expected Y per edge, monitor checks after each edge.
module tb_gate_test;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       A, B, C, D, E, F;
    logic       en;
    logic [1:0] mode;
    logic       Y;
    logic [7:0] cnt_dut;

`ifdef GATE_TEST_TOGGLE_CNT_EN
    logic [7:0] toggle_cnt;
    assign cnt_dut = toggle_cnt;
`else
    assign cnt_dut = 8'd0;
`endif

    gate_test dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .E     (E),
        .F     (F),
        .en    (en),
        .mode  (mode),
        .Y     (Y)
`ifdef GATE_TEST_TOGGLE_CNT_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tgt;
        logic       y;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    logic       y_m   = 1'b0;
    logic [7:0] cnt_m = 8'd0;
    bit         in_rst = 1'b1;

    function automatic logic ref_f(input logic [5:0] v, input logic [1:0] m);
        logic a, b, c, d, e, f;
        {a, b, c, d, e, f} = v;
        case (m)
            2'd0:    return !((a && b) || (c && d) || (e && f));
            2'd1:    return  ((a && b) || (c && d) || (e && f));
            2'd2:    return !((a || b) && (c || d) && (e || f));
            default: return logic'($countones(v) % 2);
        endcase
    endfunction

    task automatic check(input string nm, input logic exp_y, input logic [7:0] exp_cnt);
        n_check++;
        if ($isunknown(Y) || Y !== exp_y) begin
            n_fail++;
            $display("FAIL %s: Y=%b expected %b (cycle %0d)", nm, Y, exp_y, cyc);
        end
`ifdef GATE_TEST_TOGGLE_CNT_EN
        n_check++;
        if (cnt_dut !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s: toggle_cnt=%0d expected %0d (cycle %0d)", nm, cnt_dut, exp_cnt, cyc);
        end
`else
        if (exp_cnt != exp_cnt) n_fail++;
`endif
    endtask

    // Monitor: one cycle tick per edge, pops every expectation due at this edge
    initial begin
        exp_t it;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                it = q.pop_front();
                if (it.tgt != cyc) begin
                    n_check++;
                    n_fail++;
                    $display("FAIL %s: expectation missed its edge, due %0d now %0d", it.name, it.tgt, cyc);
                end else begin
                    check(it.name, it.y, it.cnt);
                end
            end
        end
    end

    // Drive one sample at the falling edge and queue the response due at the next rising edge
    task automatic apply(input logic [5:0] v, input logic [1:0] m, input logic e,
                         input logic exp_y, input string nm);
        exp_t it;
        @(negedge clk);
        {A, B, C, D, E, F} = v;
        mode = m;
        en   = e;
        if (e && !in_rst) begin
            if (exp_y != y_m && cnt_m != 8'hFF) cnt_m++;
            y_m = exp_y;
        end
        it.tgt  = cyc + 1;
        it.y    = y_m;
        it.cnt  = cnt_m;
        it.name = nm;
        q.push_back(it);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        {A, B, C, D, E, F} = 6'b111111;
        #1;
        check("reset_t0", 1'b0, 8'd0);

        apply(6'b111111, 2'd1, 1'b1, 1'b0, "in_reset_en1");
        apply(6'b111111, 2'd1, 1'b1, 1'b0, "in_reset_en1b");
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;

        // Mode 0 sequence with hand-derived results
        apply(6'b100100, 2'd0, 1'b1, 1'b1, "seq_row1");
        apply(6'b001100, 2'd0, 1'b1, 1'b0, "seq_row2");
        apply(6'b100100, 2'd0, 1'b1, 1'b1, "seq_row3");
        apply(6'b100101, 2'd0, 1'b1, 1'b1, "seq_f1");

        // All modes with A=B=1
        apply(6'b110000, 2'd0, 1'b1, 1'b0, "modes_aoi");
        apply(6'b110000, 2'd1, 1'b1, 1'b1, "modes_ao");
        apply(6'b110000, 2'd2, 1'b1, 1'b1, "modes_oai");
        apply(6'b110000, 2'd3, 1'b1, 1'b0, "modes_xor");
        apply(6'b100000, 2'd3, 1'b1, 1'b1, "modes_xor_odd");
        apply(6'b000011, 2'd2, 1'b1, 1'b1, "mode_data_same_edge");

        // Hold with en low while data and mode move
        apply(6'b100100, 2'd0, 1'b1, 1'b1, "hold_setup");
        apply(6'b001100, 2'd0, 1'b0, 1'b0, "hold1");
        apply(6'b001100, 2'd2, 1'b0, 1'b0, "hold2");
        apply(6'b001100, 2'd0, 1'b0, 1'b0, "hold3");
        apply(6'b001100, 2'd0, 1'b1, 1'b0, "hold_release");

        for (int m = 0; m < 4; m++) begin
            for (int v = 0; v < 64; v++) begin
                apply(6'(v), 2'(m), 1'b1, ref_f(6'(v), 2'(m)), $sformatf("exh_m%0d_v%0d", m, v));
            end
        end

        // Async reset mid-cycle with a changing sample pending
        apply(6'b111111, 2'd1, 1'b1, 1'b1, "pre_reset");
        @(posedge clk);
        #1;
        {A, B, C, D, E, F} = 6'b000000;
        mode = 2'd0;
        #1;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        y_m    = 1'b0;
        cnt_m  = 8'd0;
        #1;
        check("reset_async", 1'b0, 8'd0);
        apply(6'b111111, 2'd1, 1'b1, 1'b0, "reset_held");
        apply(6'b000000, 2'd0, 1'b1, 1'b0, "reset_held2");
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        apply(6'b111111, 2'd1, 1'b1, 1'b1, "resume");

        // 300 Y transitions via XOR parity
        for (int i = 0; i < 300; i++) begin
            apply((i % 2 == 0) ? 6'b000000 : 6'b100000, 2'd3, 1'b1,
                  (i % 2 == 0) ? 1'b0 : 1'b1, $sformatf("toggle_%0d", i));
        end

        repeat (3) @(posedge clk);
        #2;
`ifdef GATE_TEST_TOGGLE_CNT_EN
        n_check++;
        if (toggle_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL cnt_saturate: toggle_cnt=%0d expected 255", toggle_cnt);
        end
`endif
        rst_n  = 1'b0;
        in_rst = 1'b1;
        y_m    = 1'b0;
        cnt_m  = 8'd0;
        #1;
        check("reset_cnt_clear", 1'b0, 8'd0);

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_check++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
